jtframe_rst_seq: RTL and testbench



---
 rtl/jtframe_rst_seq.sv | 154 +++++++++++++++
 tb/tb_jtframe_rst_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_rst_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jtframe_rst_seq                                               |
// | Purpose  : PLL-lock / button / SDRAM-init reset sequencer driving the    |
// |            clock block's game_rst. JTFRAME_RSTSEQ_DEBOUNCE_EN enables    |
// |            the btn_rst debouncer.                                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module jtframe_rst_seq #(
    parameter int LOCK_WAIT = 1024,
    parameter int HOLD      = 4096,
    parameter int DEB       = 65536
)(
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
    input  logic btn_rst,
    input  logic sdram_init_done,
    output logic sdram_init,
    output logic game_rst,
    output logic ready
);
    localparam int c_max = (LOCK_WAIT > HOLD) ? LOCK_WAIT : HOLD;
    localparam int c_cw  = $clog2(c_max) + 1;
    localparam logic [c_cw-1:0] c_lock_end = c_cw'(LOCK_WAIT - 1);
    localparam logic [c_cw-1:0] c_hold_end = c_cw'(HOLD - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_INIT      = 2'd1,
        S_HOLD      = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_cw-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]      r_lock_sync, r_btn_sync;
    logic            w_lock_s, w_btn_s, w_btn;
    logic            r_sdram_init, r_game_rst, r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_sync <= 2'b00;
            r_btn_sync  <= 2'b00;
        end else begin
            r_lock_sync <= {r_lock_sync[0], pll_locked};
            r_btn_sync  <= {r_btn_sync[0], btn_rst};
        end
    end

    assign w_lock_s = r_lock_sync[1];
    assign w_btn_s  = r_btn_sync[1];

`ifdef JTFRAME_RSTSEQ_DEBOUNCE_EN
    localparam int c_dw = $clog2(DEB) + 1;
    localparam logic [c_dw-1:0] c_deb_end = c_dw'(DEB - 1);

    logic [c_dw-1:0] r_deb_cnt;
    logic            r_btn_deb;

    // The debounced level flips once btn_s has disagreed with it for DEB cycles in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_cnt <= '0;
            r_btn_deb <= 1'b0;
        end else if (w_btn_s != r_btn_deb) begin
            if (r_deb_cnt == c_deb_end) begin
                r_deb_cnt <= '0;
                r_btn_deb <= w_btn_s;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end else begin
            r_deb_cnt <= '0;
        end
    end

    assign w_btn = r_btn_deb;
`else
    // DEB has no effect in this build; the term below is constant true.
    assign w_btn = w_btn_s && (DEB >= 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_WAIT_LOCK;
            r_cnt        <= '0;
            r_sdram_init <= 1'b0;
            r_game_rst   <= 1'b1;
            r_ready      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sdram_init <= (w_state_nxt == S_INIT);
            r_game_rst   <= (w_state_nxt != S_RUN);
            r_ready      <= (w_state_nxt == S_RUN);
        end
    end

    // Lock loss outranks everything and is the only way back to SDRAM init.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state != S_WAIT_LOCK && !w_lock_s) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    if (!w_lock_s) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt == c_lock_end) begin
                        w_state_nxt = S_INIT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_INIT: begin
                    if (sdram_init_done) begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = '0;
                    end
                end
                S_HOLD: begin
                    if (w_btn) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt == c_hold_end) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_btn) begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign sdram_init = r_sdram_init;
    assign game_rst   = r_game_rst;
    assign ready      = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_rst_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_jtframe_rst_seq                                            |
// | Purpose  : Directed bench for jtframe_rst_seq (LOCK_WAIT=8, HOLD=16,     |
// |            DEB=4); honours JTFRAME_RSTSEQ_DEBOUNCE_EN.                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_jtframe_rst_seq;
`ifdef JTFRAME_RSTSEQ_DEBOUNCE_EN
    localparam int c_debx = 4;
`else
    localparam int c_debx = 0;
`endif
    // Edges from the first FF1 sample of a button change to the game_rst response.
    localparam int c_btn_lat = 2 + c_debx;
    localparam int c_rel_lat = 1 + c_debx + 16;

    logic clk, rst_n, pll_locked, btn_rst, sdram_init_done;
    logic sdram_init, game_rst, ready;
    int   n_vec = 0;
    int   n_err = 0;

    jtframe_rst_seq #(.LOCK_WAIT(8), .HOLD(16), .DEB(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pll_locked      (pll_locked),
        .btn_rst         (btn_rst),
        .sdram_init_done (sdram_init_done),
        .sdram_init      (sdram_init),
        .game_rst        (game_rst),
        .ready           (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entry: pll_locked already high, next edge is N (first FF1 sample of lock).
    task automatic seq_check(input string tag, input int done_delay);
        tick;
        for (int k = 1; k <= 8; k++) begin
            tick;
            check({tag, "_pre_init"}, sdram_init, 0);
            check({tag, "_pre_rst"}, game_rst, 1);
        end
        tick;
        check({tag, "_init_rise"}, sdram_init, 1);
        check({tag, "_init_rst"}, game_rst, 1);
        for (int d = 0; d < done_delay; d++) begin
            tick;
            check({tag, "_init_held"}, sdram_init, 1);
            check({tag, "_init_held_rst"}, game_rst, 1);
        end
        sdram_init_done = 1'b1;
        tick;
        check({tag, "_init_fall"}, sdram_init, 0);
        for (int j = 1; j <= 16; j++) begin
            tick;
            check({tag, "_hold_rst"}, game_rst, (j < 16) ? 1 : 0);
            check({tag, "_hold_ready"}, ready, (j == 16) ? 1 : 0);
        end
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            tick;
            n++;
        end
        check({tag, "_reach_run"}, ready, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pll_locked = 1'b0; btn_rst = 1'b0; sdram_init_done = 1'b0;
        repeat (3) tick;
        check("rst_game_rst", game_rst, 1);
        check("rst_sdram_init", sdram_init, 0);
        check("rst_ready", ready, 0);
        rst_n = 1'b1;
        repeat (3) tick;
        check("nolock_game_rst", game_rst, 1);

        // Full power-up with done tied high
        sdram_init_done = 1'b1;
        pll_locked = 1'b1;
        seq_check("t1", 0);

        // Button held 50 cycles in RUN, then released
        btn_rst = 1'b1;
        tick;
        for (int j = 0; j <= c_btn_lat; j++) begin
            if (j > 0) tick;
            check("t4_press", game_rst, (j >= c_btn_lat) ? 1 : 0);
        end
        repeat (50 - (c_btn_lat + 1)) begin
            tick;
            check("t4_held_rst", game_rst, 1);
            check("t4_held_init", sdram_init, 0);
        end
        btn_rst = 1'b0;
        tick;
        for (int j = 0; j <= c_rel_lat; j++) begin
            if (j > 0) tick;
            check("t4_release", game_rst, (j < c_rel_lat) ? 1 : 0);
            check("t4_no_init", sdram_init, 0);
        end

        // Lock loss in RUN, then a complete re-sequence including INIT
        pll_locked = 1'b0;
        tick;
        check("t5_loss_e0", game_rst, 0);
        tick;
        check("t5_loss_e1", game_rst, 0);
        tick;
        check("t5_loss_e2", game_rst, 1);
        check("t5_loss_ready", ready, 0);
        pll_locked = 1'b1;
        seq_check("t5", 0);

        // Lock glitch after 5 locked cycles in WAIT_LOCK restarts the count
        pll_locked = 1'b0;
        repeat (4) tick;
        pll_locked = 1'b1;
        repeat (6) begin
            tick;
            check("t2_first_lock", sdram_init, 0);
        end
        pll_locked = 1'b0;
        repeat (3) begin
            tick;
            check("t2_glitch", sdram_init, 0);
        end
        pll_locked = 1'b1;
        seq_check("t2", 0);

        // sdram_init_done withheld for 100 cycles
        pll_locked = 1'b0;
        repeat (4) tick;
        sdram_init_done = 1'b0;
        pll_locked = 1'b1;
        seq_check("t3", 100);

`ifdef JTFRAME_RSTSEQ_DEBOUNCE_EN
        // Short pulse is filtered, long pulse resets after sync + DEB
        btn_rst = 1'b1;
        repeat (3) tick;
        btn_rst = 1'b0;
        repeat (10) begin
            tick;
            check("t6_short_pulse", game_rst, 0);
        end
        btn_rst = 1'b1;
        tick;
        for (int j = 1; j <= 6; j++) begin
            tick;
            check("t6_long_pulse", game_rst, (j >= 6) ? 1 : 0);
            if (j == 5) btn_rst = 1'b0;
        end
        btn_rst = 1'b0;
        wait_run("t6");
`endif

        // Asynchronous reset in RUN
        #2 rst_n = 1'b0;
        #1;
        check("arst_run_ready", ready, 0);
        check("arst_run_game_rst", game_rst, 1);
        tick;
        tick;
        rst_n = 1'b1;
        sdram_init_done = 1'b0;
        repeat (10) tick;
        check("arst_pre_init", sdram_init, 1);

        // Asynchronous reset in INIT
        #2 rst_n = 1'b0;
        #1;
        check("arst_init_sdram", sdram_init, 0);
        check("arst_init_game_rst", game_rst, 1);
        tick;
        rst_n = 1'b1;
        sdram_init_done = 1'b1;
        seq_check("arst_init", 0);

        // Asynchronous reset in HOLD, then restart from WAIT_LOCK
        btn_rst = 1'b1;
        repeat (c_btn_lat + 1) tick;
        check("arst_hold_entry", game_rst, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hold_game_rst", game_rst, 1);
        check("arst_hold_sdram", sdram_init, 0);
        check("arst_hold_ready", ready, 0);
        btn_rst = 1'b0;
        tick;
        rst_n = 1'b1;
        seq_check("arst_hold", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
